// File: rtl/step_sequencer_counter_pkg.sv
// Shared definitions for the multiplier step sequencer: FSM encoding and
// the default geometry used by the multiplier top level.
package step_sequencer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH   = 2;
  localparam int DEFAULT_MODULUS = 4;

endpackage

// File: rtl/step_sequencer_counter_mod_counter.sv
// WIDTH-bit modulo-MODULUS step register with increment and clear inputs.
// wrap flags the increment that rolls the count from MODULUS-1 back to 0.
module mod_counter
  import step_sequencer_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap  = inc && (count_q == LAST);
  assign count = count_q;

  // clr wins over inc so the FSM can force zero regardless of enable
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/step_sequencer_counter.sv
// Run-controlled step sequencer for the sequential multiplier: IDLE/RUN/DONE
// FSM driving a modulo counter that selects the current partial product.
module step_sequencer_counter
  import step_sequencer_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             enable,
  input  logic             sclr,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             last,
  output logic             done
);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $fatal(1, "step_sequencer_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  state_t state_q;
  state_t state_d;
  logic   done_q;
  logic   done_d;
  logic   cnt_inc;
  logic   cnt_clr;
  logic   cnt_wrap;

  mod_counter #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_mod_counter (
    .clk   (clk),
    .aclr_n(aclr_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (count_out),
    .wrap  (cnt_wrap)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Outside RUN the counter is held at zero, so every run starts from step 0
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (sclr) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_clr = 1'b1;
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          cnt_inc = enable;
          if (cnt_wrap) state_d = ST_DONE;
        end
        ST_DONE: begin
          cnt_clr = 1'b1;
          state_d = start ? ST_RUN : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    last = busy && (count_out == LAST);
    done = done_q;
  end

endmodule

// File: tb/tb_step_sequencer_counter.sv
// Scoreboarded random test of two sequencer instances (2-bit/mod-4 and
// 3-bit/mod-5) driven with identical stimulus against a run-level model.
module tb_step_sequencer_counter;

  logic       clk = 1'b0;
  logic       aclr_n = 1'b0;
  logic       start = 1'b1;
  logic       enable = 1'b0;
  logic       sclr = 1'b0;
  logic [1:0] count4;
  logic       busy4, last4, done4;
  logic [2:0] count5;
  logic       busy5, last5, done5;

  typedef struct packed {
    logic [3:0] cnt;
    logic       busy;
    logic       last;
    logic       done;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cycle_no  = 0;

  // Run-level model: a run is "in_run" with a number of completed steps
  bit in_run[2];
  int steps[2];
  bit done_now[2];
  int mods[2] = '{4, 5};

  always #5 clk = ~clk;

  step_sequencer_counter #(.WIDTH(2), .MODULUS(4)) dut4 (
    .clk(clk), .aclr_n(aclr_n), .start(start), .enable(enable), .sclr(sclr),
    .count_out(count4), .busy(busy4), .last(last4), .done(done4)
  );

  step_sequencer_counter #(.WIDTH(3), .MODULUS(5)) dut5 (
    .clk(clk), .aclr_n(aclr_n), .start(start), .enable(enable), .sclr(sclr),
    .count_out(count5), .busy(busy5), .last(last5), .done(done5)
  );

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cycle_no, act, req);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt4"}, int'(count4), 0);
    chk({tag, "_busy4"}, int'(busy4), 0);
    chk({tag, "_done4"}, int'(done4), 0);
    chk({tag, "_cnt5"}, int'(count5), 0);
    chk({tag, "_busy5"}, int'(busy5), 0);
    chk({tag, "_last5"}, int'(last5), 0);
  endtask

  function automatic exp_t expect_of(input int i);
    exp_t e;
    e.cnt  = 4'(steps[i]);
    e.busy = in_run[i];
    e.last = in_run[i] && (steps[i] == mods[i] - 1);
    e.done = done_now[i];
    return e;
  endfunction

  task automatic model_step(input bit st, input bit en, input bit sc, input bit ar);
    for (int i = 0; i < 2; i++) begin
      if (!ar || sc) begin
        in_run[i] = 0; steps[i] = 0; done_now[i] = 0;
      end else if (in_run[i]) begin
        done_now[i] = 0;
        if (en) begin
          steps[i]++;
          if (steps[i] == mods[i]) begin
            in_run[i] = 0; steps[i] = 0; done_now[i] = 1;
          end
        end
      end else begin
        done_now[i] = 0;
        if (st) begin
          in_run[i] = 1; steps[i] = 0;
        end
      end
    end
    q4.push_back(expect_of(0));
    q5.push_back(expect_of(1));
  endtask

  // One clock of stimulus; ar is the aclr_n level seen by the coming edge
  task automatic cycle(input bit st, input bit en, input bit sc, input bit ar);
    @(negedge clk);
    #2;
    if (!ar && aclr_n) begin
      aclr_n = 1'b0;
      #1;
      chk_zero("async_assert");
    end else if (ar && !aclr_n) begin
      aclr_n = 1'b1;
      #1;
      chk_zero("release_hold");
    end
    start = st; enable = en; sclr = sc;
    model_step(st, en, sc, ar);
  endtask

  // Monitor: every edge yields one response per instance
  initial begin
    exp_t e4, e5;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (q4.size() > 0 && q5.size() > 0) begin
        e4 = q4.pop_front();
        e5 = q5.pop_front();
        chk("count4", int'(count4), int'(e4.cnt));
        chk("busy4", int'(busy4), int'(e4.busy));
        chk("last4", int'(last4), int'(e4.last));
        chk("done4", int'(done4), int'(e4.done));
        chk("count5", int'(count5), int'(e5.cnt));
        chk("busy5", int'(busy5), int'(e5.busy));
        chk("last5", int'(last5), int'(e5.last));
        chk("done5", int'(done5), int'(e5.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_run[i] = 0; steps[i] = 0; done_now[i] = 0;
    end
    #1;
    chk_zero("reset_t0");
    // reset held with start high, then released mid-low-clock
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    // full run with enable held high, start also high while busy
    cycle(1, 1, 0, 1);
    for (int i = 0; i < 6; i++) cycle(i == 2, 1, 0, 1);
    cycle(0, 0, 0, 1);
    // enable gaps
    cycle(1, 0, 0, 1);
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      foreach (pat[i]) cycle(1'b0, pat[i], 0, 1);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1);
    // back-to-back: start during the DONE cycle of the mod-4 instance
    cycle(1, 1, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1);
    cycle(1, 1, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1);
    // sclr abort at count 2
    cycle(1, 1, 0, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    cycle(1, 1, 1, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    // aclr_n abort at count 2
    cycle(1, 1, 0, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) >= 2);
    end
    cycle(0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("drain4", q4.size(), 0);
    chk("drain5", q5.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
